// File: rtl/rf_access_if.sv
// rf_access_if: command, write-data and read-data streams of rf_access_master.
//
// Handshake rule for all three streams: a beat transfers on a rising clock edge
// where valid and ready are both high. Once a producer raises valid, it holds
// valid and its payload stable until that transfer edge. Ready may change at any
// time and is never a function of valid.
interface rf_access_if #(
  parameter int DW = 64,
  parameter int AW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [3:0]    cmd_len;

  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;

  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          rd_last;

  // Command/stream source side (sequencer or bus slave).
  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  cmd_ready,
    output wr_valid, wr_data,
    input  wr_ready,
    input  rd_valid, rd_data, rd_last,
    output rd_ready
  );

  // Register-file initiator side.
  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    output cmd_ready,
    input  wr_valid, wr_data,
    output wr_ready,
    output rd_valid, rd_data, rd_last,
    input  rd_ready
  );
endinterface

// File: rtl/rf_access_master.sv
// rf_access_master: burst initiator for the FactoCore register file.
// Accepts read/write burst commands and walks sequential register addresses,
// returning read data as a back-pressurable stream and consuming write data
// as a stream.
// Optional feature macro: RFACC_RANGE_CHECK_EN (reject bursts that run past
// register NREG-1 with a done+err pulse and no register file access).
module rf_access_master #(
  parameter int DW   = 64,
  parameter int AW   = 8,
  parameter int NREG = 7
) (
  input  logic          clk,
  input  logic          reset,
  rf_access_if.slave    bus,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] wAddr,
  output logic [DW-1:0] wData,
  output logic          we,
  output logic [AW-1:0] rAddr,
  input  logic [DW-1:0] rData,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  localparam logic [AW:0] LAST_REG = (AW+1)'(NREG - 1);

  state_t        state, state_next;
  logic [AW-1:0] cnt;        // next register address to access
  logic [4:0]    rem;        // beats still to transfer on the register file side
  logic          wr_tail;    // last write beat is committing this cycle
  logic          rd_valid_q;
  logic          rd_last_q;
  logic [DW-1:0] rd_data_q;

  logic cmd_ready_int, wr_ready_int;
  logic cmd_fire, wr_fire, rd_load, rd_end;
  logic over_range, range_bad;

  // Last address of the burst computed without wrap so 0xFF + n is caught.
  assign over_range = ({1'b0, bus.cmd_addr} + (AW+1)'(bus.cmd_len)) > LAST_REG;

`ifdef RFACC_RANGE_CHECK_EN
  assign range_bad = over_range;
`else
  // Without the check, out-of-range bursts wrap through the address space.
  logic unused_range;
  assign unused_range = over_range;
  assign range_bad    = 1'b0;
`endif

  // New commands wait out the commit cycle of a finished write burst so that
  // cmd_ready and done rise together.
  assign cmd_ready_int = (state == S_IDLE) && !reset && !wr_tail;
  assign wr_ready_int  = (state == S_WRITE) && !reset;
  assign cmd_fire      = bus.cmd_valid && cmd_ready_int;
  assign wr_fire       = bus.wr_valid && wr_ready_int;
  assign rd_load       = (state == S_READ) && (rem != 5'd0) && (!rd_valid_q || bus.rd_ready);
  assign rd_end        = (state == S_READ) && rd_valid_q && bus.rd_ready && rd_last_q;

  assign bus.cmd_ready = cmd_ready_int;
  assign bus.wr_ready  = wr_ready_int;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_last   = rd_last_q;
  assign bus.rd_data   = rd_data_q;
  assign busy          = (state != S_IDLE) && !reset;
  assign rAddr         = cnt;
  assign dbg_state     = state;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state decode: bursts end on consumption of the last read beat or
  // acceptance of the last write beat.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (cmd_fire && !range_bad) state_next = bus.cmd_write ? S_WRITE : S_READ;
      S_READ:  if (rd_end) state_next = S_IDLE;
      S_WRITE: if (wr_fire && (rem == 5'd1)) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: address counter, beat counter, read holding register and
  // registered register-file write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      rem        <= '0;
      wr_tail    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
      we         <= 1'b0;
      wAddr      <= '0;
      wData      <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done    <= rd_end || wr_tail || (cmd_fire && range_bad);
      err     <= cmd_fire && range_bad;
      wr_tail <= wr_fire && (rem == 5'd1);
      we      <= wr_fire;

      if (cmd_fire && !range_bad) begin
        cnt <= bus.cmd_addr;
        rem <= {1'b0, bus.cmd_len} + 5'd1;
      end

      if (wr_fire) begin
        wAddr <= cnt;
        wData <= bus.wr_data;
        cnt   <= cnt + AW'(1);
        rem   <= rem - 5'd1;
      end

      if (rd_load) begin
        rd_data_q  <= rData;
        rd_valid_q <= 1'b1;
        rd_last_q  <= (rem == 5'd1);
        cnt        <= cnt + AW'(1);
        rem        <= rem - 5'd1;
      end else if ((state == S_READ) && bus.rd_ready) begin
        rd_valid_q <= 1'b0;
        rd_last_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rf_access_master.sv
// tb_rf_access_master: directed and randomised checks of rf_access_master
// against a behavioural register file and an expected-value scoreboard.
module tb_rf_access_master;
  localparam int DW   = 64;
  localparam int AW   = 8;
  localparam int NREG = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rf_access_if #(.DW(DW), .AW(AW)) bus ();

  logic          busy, done, err, we;
  logic [AW-1:0] wAddr, rAddr;
  logic [DW-1:0] wData, rData;
  logic [1:0]    dbg_state;

  rf_access_master #(.DW(DW), .AW(AW), .NREG(NREG)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .wAddr     (wAddr),
    .wData     (wData),
    .we        (we),
    .rAddr     (rAddr),
    .rData     (rData),
    .dbg_state (dbg_state)
  );

  // ---------------- register file model ----------------
  logic          rf_init;
  logic [DW-1:0] rf_mem [256];

  function automatic logic [DW-1:0] init_word(input logic [7:0] a);
    return {56'hA5A50000_5A5A00, a};
  endfunction

  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 256; i++) rf_mem[i] <= init_word(8'(i));
    end else if (we) begin
      rf_mem[wAddr] <= wData;
    end
  end
  assign rData = rf_mem[rAddr];

  // ---------------- scoreboard ----------------
  logic [DW-1:0]    exp_q[$];
  logic [AW+DW-1:0] exp_w_q[$];
  logic [DW-1:0]    shadow [NREG];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; rf_init = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;
    repeat (3) tick();
    rf_init = 1'b0;
    n_checks++;
    if ({bus.cmd_ready, bus.wr_ready, busy, bus.rd_valid, bus.rd_last, we, done, err} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_flags got=%b exp=00000000",
               {bus.cmd_ready, bus.wr_ready, busy, bus.rd_valid, bus.rd_last, we, done, err});
    end
    n_checks++;
    if (bus.rd_data !== '0 || wData !== '0) begin
      n_fail++; $display("FAIL reset_data got=%h/%h exp=0/0", bus.rd_data, wData);
    end
    n_checks++;
    if (wAddr !== '0 || rAddr !== '0) begin
      n_fail++; $display("FAIL reset_addr got=%h/%h exp=0/0", wAddr, rAddr);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_cmd_ready got=%b exp=1", bus.cmd_ready);
    end
    n_checks++;
    if (dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL reset_state got=%0d exp=0", dbg_state);
    end
  endtask

  task automatic test_idle_streams();
    bus.wr_valid = 1'b1; bus.wr_data = 64'h1234; bus.rd_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (bus.wr_ready !== 1'b0 || we !== 1'b0 || bus.rd_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_streams got=wr_ready%b we%b rd_valid%b exp=000",
                 bus.wr_ready, we, bus.rd_valid);
      end
    end
    bus.wr_valid = 1'b0; bus.rd_ready = 1'b0;
  endtask

  task automatic test_write_burst();
    logic [DW-1:0]    d;
    logic [AW+DW-1:0] e;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 8'd0; bus.cmd_len = 4'd6;
    tick();
    bus.cmd_valid = 1'b0;
    n_checks++;
    if (bus.wr_ready !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL wb_enter got=wr_ready%b busy%b exp=11", bus.wr_ready, busy);
    end
    for (int k = 0; k < 7; k++) begin
      d = 64'h11 * 64'(k + 1);
      bus.wr_valid = 1'b1; bus.wr_data = d;
      exp_w_q.push_back({8'(k), d});
      tick();
      n_checks++;
      if (we !== 1'b1) begin
        n_fail++; $display("FAIL wb_we beat%0d got=%b exp=1", k, we);
      end else begin
        e = exp_w_q.pop_front();
        if ({wAddr, wData} !== e) begin
          n_fail++; $display("FAIL wb_beat%0d got=%h exp=%h", k, {wAddr, wData}, e);
        end
      end
    end
    bus.wr_valid = 1'b0;
    n_checks++;
    if (done !== 1'b0 || bus.cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL wb_early got=done%b cmd_ready%b exp=00", done, bus.cmd_ready);
    end
    tick();
    n_checks++;
    if (done !== 1'b1 || we !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wb_done got=done%b we%b cmd_ready%b exp=101", done, we, bus.cmd_ready);
    end
    n_checks++;
    if (rf_mem[6] !== 64'h77) begin
      n_fail++; $display("FAIL wb_commit got=%h exp=77", rf_mem[6]);
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL wb_done_pulse got=%b exp=0", done);
    end
  endtask

  task automatic test_read_backpressure();
    logic [DW-1:0] e;
    logic          rdy;
    int            cyc;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 8'd0; bus.cmd_len = 4'd6;
    for (int k = 0; k < 7; k++) exp_q.push_back(64'h11 * 64'(k + 1));
    tick();
    bus.cmd_valid = 1'b0;
    n_checks++;
    if (bus.rd_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rb_accept got=rd_valid%b busy%b exp=01", bus.rd_valid, busy);
    end
    tick();
    n_checks++;
    if (bus.rd_valid !== 1'b1) begin
      n_fail++; $display("FAIL rb_first_valid got=%b exp=1", bus.rd_valid);
    end
    rdy = 1'b1; cyc = 0;
    while (exp_q.size() != 0 && cyc < 60) begin
      bus.rd_ready = rdy; rdy = ~rdy;
      if (bus.rd_valid && bus.rd_ready) begin
        e = exp_q.pop_front();
        n_checks++;
        if (bus.rd_data !== e) begin
          n_fail++; $display("FAIL rb_data got=%h exp=%h", bus.rd_data, e);
        end
        n_checks++;
        if (bus.rd_last !== (exp_q.size() == 0)) begin
          n_fail++; $display("FAIL rb_last got=%b exp=%b", bus.rd_last, exp_q.size() == 0);
        end
      end
      tick(); cyc++;
    end
    bus.rd_ready = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL rb_timeout got=%0d_left exp=0_left", exp_q.size());
      exp_q.delete();
    end
    n_checks++;
    if (done !== 1'b1 || bus.rd_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rb_done got=done%b rd_valid%b cmd_ready%b exp=101",
               done, bus.rd_valid, bus.cmd_ready);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || bus.rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL rb_after got=done%b rd_valid%b exp=00", done, bus.rd_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] e;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 8'd3; bus.cmd_len = 4'd0;
    tick();
    bus.cmd_valid = 1'b0;
    bus.wr_valid = 1'b1; bus.wr_data = 64'hDEADBEEF_CAFEF00D;
    tick();
    bus.wr_valid = 1'b0;
    n_checks++;
    if (we !== 1'b1 || wAddr !== 8'd3) begin
      n_fail++; $display("FAIL b2b_write got=we%b addr%h exp=we1 addr03", we, wAddr);
    end
    tick();
    n_checks++;
    if (done !== 1'b1 || bus.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_done got=done%b cmd_ready%b exp=11", done, bus.cmd_ready);
    end
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 8'd3; bus.cmd_len = 4'd0;
    bus.rd_ready = 1'b1;
    exp_q.push_back(64'hDEADBEEF_CAFEF00D);
    tick();
    bus.cmd_valid = 1'b0;
    n_checks++;
    if (rAddr !== 8'd3) begin
      n_fail++; $display("FAIL b2b_raddr got=%h exp=03", rAddr);
    end
    tick();
    e = exp_q.pop_front();
    n_checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_last !== 1'b1 || bus.rd_data !== e) begin
      n_fail++;
      $display("FAIL b2b_read got=v%b l%b %h exp=v1 l1 %h",
               bus.rd_valid, bus.rd_last, bus.rd_data, e);
    end
    tick();
    bus.rd_ready = 1'b0;
    n_checks++;
    if (done !== 1'b1 || bus.rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_read_done got=done%b rd_valid%b exp=10", done, bus.rd_valid);
    end
  endtask

`ifndef RFACC_RANGE_CHECK_EN
  task automatic test_wrap_reset();
    logic [DW-1:0] e;
    bus.rd_ready = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 8'hFE; bus.cmd_len = 4'd2;
    exp_q.push_back(init_word(8'hFE));
    exp_q.push_back(init_word(8'hFF));
    tick();
    bus.cmd_valid = 1'b0;
    n_checks++;
    if (rAddr !== 8'hFE) begin
      n_fail++; $display("FAIL wrap_raddr0 got=%h exp=fe", rAddr);
    end
    tick();
    e = exp_q.pop_front();
    n_checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== e || rAddr !== 8'hFF) begin
      n_fail++;
      $display("FAIL wrap_beat0 got=v%b %h raddr%h exp=v1 %h raddrff",
               bus.rd_valid, bus.rd_data, rAddr, e);
    end
    tick();
    e = exp_q.pop_front();
    n_checks++;
    if (bus.rd_data !== e || rAddr !== 8'h00 || bus.rd_last !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_beat1 got=%h raddr%h l%b exp=%h raddr00 l0",
               bus.rd_data, rAddr, bus.rd_last, e);
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if (bus.rd_valid !== 1'b0 || dbg_state !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_reset got=v%b st%0d busy%b done%b exp=v0 st0 busy0 done0",
               bus.rd_valid, dbg_state, busy, done);
    end
    reset = 1'b0; bus.rd_ready = 1'b0;
    tick();
  endtask
`endif

  task automatic test_random();
    logic [DW-1:0]    d, e;
    logic [AW+DW-1:0] ew;
    logic             fire;
    int               a, l, beats, cyc;
    logic             wr;
    // Register contents left by the earlier directed scenarios.
    for (int k = 0; k < NREG; k++) shadow[k] = 64'h11 * 64'(k + 1);
    shadow[3] = 64'hDEADBEEF_CAFEF00D;
    for (int it = 0; it < 10; it++) begin
      wr = 1'($urandom_range(0, 1));
      a  = $urandom_range(0, 3);
      l  = $urandom_range(0, 3);
      n_checks++;
      if (bus.cmd_ready !== 1'b1) begin
        n_fail++; $display("FAIL rnd_cmd_ready it%0d got=%b exp=1", it, bus.cmd_ready);
      end
      bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = 8'(a); bus.cmd_len = 4'(l);
      if (!wr) for (int k = 0; k <= l; k++) exp_q.push_back(shadow[a + k]);
      tick();
      bus.cmd_valid = 1'b0;
      cyc = 0;
      if (wr) begin
        beats = 0;
        while (beats <= l && cyc < 100) begin
          bus.wr_valid = 1'($urandom_range(0, 1));
          fire = bus.wr_valid && bus.wr_ready;
          if (fire) begin
            d = {$urandom, $urandom};
            bus.wr_data = d;
            exp_w_q.push_back({8'(a + beats), d});
            shadow[a + beats] = d;
            beats++;
          end
          tick(); cyc++;
          n_checks++;
          if (we !== fire) begin
            n_fail++; $display("FAIL rnd_we got=%b exp=%b", we, fire);
          end else if (fire) begin
            ew = exp_w_q.pop_front();
            if ({wAddr, wData} !== ew) begin
              n_fail++; $display("FAIL rnd_wbeat got=%h exp=%h", {wAddr, wData}, ew);
            end
          end
        end
        bus.wr_valid = 1'b0;
        tick();
        n_checks++;
        if (done !== 1'b1 || beats <= l) begin
          n_fail++; $display("FAIL rnd_wdone got=done%b beats%0d exp=done1 beats%0d", done, beats, l + 1);
        end
      end else begin
        while (exp_q.size() != 0 && cyc < 100) begin
          bus.rd_ready = 1'($urandom_range(0, 1));
          if (bus.rd_valid && bus.rd_ready) begin
            e = exp_q.pop_front();
            n_checks++;
            if (bus.rd_data !== e || bus.rd_last !== (exp_q.size() == 0)) begin
              n_fail++;
              $display("FAIL rnd_rbeat got=%h l%b exp=%h l%b",
                       bus.rd_data, bus.rd_last, e, exp_q.size() == 0);
            end
          end
          tick(); cyc++;
        end
        bus.rd_ready = 1'b0;
        n_checks++;
        if (exp_q.size() != 0 || done !== 1'b1) begin
          n_fail++; $display("FAIL rnd_rdone got=left%0d done%b exp=left0 done1", exp_q.size(), done);
          exp_q.delete();
        end
      end
    end
  endtask

`ifdef RFACC_RANGE_CHECK_EN
  task automatic test_range_check();
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 8'd5; bus.cmd_len = 4'd3;
    bus.wr_valid = 1'b1; bus.wr_data = 64'hBAD;
    tick();
    bus.cmd_valid = 1'b0;
    n_checks++;
    if (done !== 1'b1 || err !== 1'b1 || we !== 1'b0 || bus.wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL range_pulse got=done%b err%b we%b wr_ready%b exp=1100",
               done, err, we, bus.wr_ready);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || err !== 1'b0 || we !== 1'b0 || bus.wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL range_after got=done%b err%b we%b wr_ready%b exp=0000",
               done, err, we, bus.wr_ready);
    end
    bus.wr_valid = 1'b0;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_idle_streams();
    test_write_burst();
    test_read_backpressure();
    test_back_to_back();
`ifndef RFACC_RANGE_CHECK_EN
    test_wrap_reset();
`endif
    test_random();
`ifdef RFACC_RANGE_CHECK_EN
    test_range_check();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

endmodule
